// File: rtl/btb_update_queue.sv
// btb_update_queue: producer side of the ROB->BTB update path.
// Retired branches are compacted into an in-order circular queue and drained
// onto rob_packet. Entries that share a BTB index are spread across cycles so
// that no two packets issued together update the same BTB slot.
// Optional macro BTB_UPD_BYPASS_EN: when the queue is empty, this cycle's
// branches go straight to rob_packet. Any that are held back by an index
// conflict are queued as usual.

`ifndef WIDTH
`define WIDTH 2
`endif
`ifndef XLEN
`define XLEN 32
`endif

package btb_update_queue_pkg;
  typedef struct packed {
    logic             isbranch;
    logic             uncond;
    logic             mispredict;
    logic [`XLEN-1:0] pc;
    logic [`XLEN-1:0] targetpc;
  } ROB_BTB_packet;
endpackage

module btb_update_queue
  import btb_update_queue_pkg::*;
#(
  parameter int WIDTH  = `WIDTH,
  parameter int DEPTH  = 8,
  parameter int IDX_LO = 2,
  parameter int IDX_HI = 9
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            retire_valid,
  input  logic [WIDTH-1:0]            retire_isbranch,
  input  logic [WIDTH-1:0]            retire_uncond,
  input  logic [WIDTH-1:0]            retire_mispredict,
  input  logic [WIDTH-1:0][`XLEN-1:0] retire_pc,
  input  logic [WIDTH-1:0][`XLEN-1:0] retire_targetpc,
  output logic                        retire_ready,
  output ROB_BTB_packet [WIDTH-1:0]   rob_packet,
  output logic [$clog2(DEPTH):0]      q_count,
  output logic [7:0]                  drop_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ROB_BTB_packet             mem [DEPTH];
  logic [PTR_W-1:0]          head, tail;
  logic [CNT_W-1:0]          count;

  ROB_BTB_packet [WIDTH-1:0] cand;
  logic [WIDTH-1:0]          cand_v;
  logic [CNT_W-1:0]          cand_cnt;
  ROB_BTB_packet [WIDTH-1:0] src;
  logic [WIDTH-1:0]          src_v;
  logic                      bypass;
  logic [CNT_W-1:0]          n_issue;
  logic [CNT_W-1:0]          deq_n;
  logic [CNT_W-1:0]          enq_n;
  logic [CNT_W-1:0]          enq_off;
  logic [WIDTH-1:0]          enq_we;
  logic                      drop;
  logic [8:0]                drop_sum;

`ifdef BTB_UPD_BYPASS_EN
  assign bypass = (count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign retire_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(WIDTH);
  assign q_count      = count;

  // Compact retiring branches into ascending candidate slots.
  always_comb begin
    logic [CNT_W-1:0] run;
    run    = '0;
    cand   = '0;
    cand_v = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (retire_valid[k] && retire_isbranch[k]) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (run == CNT_W'(i)) begin
            cand_v[i]          = 1'b1;
            cand[i].isbranch   = 1'b1;
            cand[i].uncond     = retire_uncond[k];
            cand[i].mispredict = retire_mispredict[k];
            cand[i].pc         = retire_pc[k];
            cand[i].targetpc   = retire_targetpc[k];
          end
        end
        run = run + CNT_W'(1);
      end
    end
    cand_cnt = run;
  end

  // Select what competes for issue: queue head entries, or fresh candidates on bypass.
  always_comb begin
    src   = '0;
    src_v = '0;
    for (int j = 0; j < WIDTH; j++) begin
      if (bypass) begin
        src[j]   = cand[j];
        src_v[j] = cand_v[j];
      end else begin
        src[j]   = mem[head + PTR_W'(j)];
        src_v[j] = (count > CNT_W'(j));
      end
    end
  end

  // Issue in order, stopping at the first empty slot or BTB index conflict.
  always_comb begin
    logic stop;
    logic hit;
    stop       = 1'b0;
    hit        = 1'b0;
    n_issue    = '0;
    rob_packet = '0;
    for (int j = 0; j < WIDTH; j++) begin
      hit = 1'b0;
      for (int p = 0; p < WIDTH; p++) begin
        if (p < j && src[p].pc[IDX_HI:IDX_LO] == src[j].pc[IDX_HI:IDX_LO])
          hit = 1'b1;
      end
      if (!src_v[j] || hit)
        stop = 1'b1;
      if (!stop) begin
        rob_packet[j] = src[j];
        n_issue       = n_issue + CNT_W'(1);
      end
    end
  end

  // Enqueue bookkeeping: bypassed candidates are skipped, overflow drops the whole group.
  always_comb begin
    enq_off  = bypass ? n_issue : '0;
    deq_n    = bypass ? '0 : n_issue;
    enq_n    = retire_ready ? (cand_cnt - enq_off) : '0;
    drop     = (cand_cnt != '0) && !retire_ready;
    drop_sum = {1'b0, drop_cnt} + 9'(cand_cnt);
    enq_we   = '0;
    for (int i = 0; i < WIDTH; i++)
      enq_we[i] = retire_ready && cand_v[i] && (CNT_W'(i) >= enq_off);
  end

  // Queue storage; stale contents are harmless because occupancy gates every read.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < WIDTH; i++)
        if (enq_we[i])
          mem[tail + PTR_W'(i) - PTR_W'(enq_off)] <= cand[i];
    end
  end

  // Pointers, occupancy and the saturating drop counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      head  <= head + PTR_W'(deq_n);
      tail  <= tail + PTR_W'(enq_n);
      count <= count + enq_n - deq_n;
      if (drop)
        drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

endmodule

// File: tb/tb_btb_update_queue.sv
// Testbench for btb_update_queue: directed vectors, fill/overflow/wrap
// sequence, mid-operation reset, and a randomized run against a queue model.

`ifndef WIDTH
`define WIDTH 2
`endif
`ifndef XLEN
`define XLEN 32
`endif

module tb_btb_update_queue;
  import btb_update_queue_pkg::*;

  localparam int W     = 2;
  localparam int DEPTH = 8;

  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic [W-1:0]            retire_valid, retire_isbranch, retire_uncond, retire_mispredict;
  logic [W-1:0][`XLEN-1:0] retire_pc, retire_targetpc;
  logic                    retire_ready;
  ROB_BTB_packet [W-1:0]   rob_packet;
  logic [3:0]              q_count;
  logic [7:0]              drop_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  btb_update_queue #(.WIDTH(W), .DEPTH(DEPTH), .IDX_LO(2), .IDX_HI(9)) dut (
    .clock            (clock),
    .reset            (reset),
    .retire_valid     (retire_valid),
    .retire_isbranch  (retire_isbranch),
    .retire_uncond    (retire_uncond),
    .retire_mispredict(retire_mispredict),
    .retire_pc        (retire_pc),
    .retire_targetpc  (retire_targetpc),
    .retire_ready     (retire_ready),
    .rob_packet       (rob_packet),
    .q_count          (q_count),
    .drop_cnt         (drop_cnt)
  );

  typedef struct {
    string         name;
    logic [1:0]    v, br, u, m;
    logic [31:0]   p0, p1, t0, t1;
    ROB_BTB_packet e1_0, e1_1, e2_0, e2_1;
    int            q1, q2;
  } vec_t;

  vec_t vecs[$];

  function automatic ROB_BTB_packet mk(input logic u, input logic m,
                                       input logic [31:0] pc, input logic [31:0] tgt);
    ROB_BTB_packet r;
    r.isbranch   = 1'b1;
    r.uncond     = u;
    r.mispredict = m;
    r.pc         = pc;
    r.targetpc   = tgt;
    return r;
  endfunction

  function automatic vec_t mkvec(input string nm, input logic [1:0] v, input logic [1:0] br,
                                 input logic [1:0] u, input logic [1:0] m,
                                 input logic [31:0] p0, input logic [31:0] p1,
                                 input logic [31:0] t0, input logic [31:0] t1,
                                 input ROB_BTB_packet a, input ROB_BTB_packet b,
                                 input ROB_BTB_packet c, input ROB_BTB_packet d,
                                 input int q1, input int q2);
    vec_t r;
    r.name = nm; r.v = v; r.br = br; r.u = u; r.m = m;
    r.p0 = p0; r.p1 = p1; r.t0 = t0; r.t1 = t1;
    r.e1_0 = a; r.e1_1 = b; r.e2_0 = c; r.e2_1 = d;
    r.q1 = q1; r.q2 = q2;
    return r;
  endfunction

  task automatic chk_pkt(input string nm, input ROB_BTB_packet act, input ROB_BTB_packet exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got br=%0b u=%0b m=%0b pc=%h tgt=%h, want br=%0b u=%0b m=%0b pc=%h tgt=%h",
               nm, act.isbranch, act.uncond, act.mispredict, act.pc, act.targetpc,
               exp.isbranch, exp.uncond, exp.mispredict, exp.pc, exp.targetpc);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] br, input logic [1:0] u,
                       input logic [1:0] m, input logic [31:0] p0, input logic [31:0] p1,
                       input logic [31:0] t0, input logic [31:0] t1);
    retire_valid       = v;
    retire_isbranch    = br;
    retire_uncond      = u;
    retire_mispredict  = m;
    retire_pc[0]       = p0;
    retire_pc[1]       = p1;
    retire_targetpc[0] = t0;
    retire_targetpc[1] = t1;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
  endtask

  function automatic logic [31:0] spc(input int n);
    return 32'h100 + (32'(n) << 10);
  endfunction

  task automatic test_reset();
    do_reset();
    chk_pkt("reset.slot0", rob_packet[0], '0);
    chk_pkt("reset.slot1", rob_packet[1], '0);
    chk_int("reset.q_count", int'(q_count), 0);
    chk_int("reset.ready", int'(retire_ready), 1);
    chk_int("reset.drop_cnt", int'(drop_cnt), 0);
  endtask

  task automatic test_vectors();
    vecs.push_back(mkvec("two_branches", 2'b11, 2'b11, 2'b10, 2'b01,
      32'h100, 32'h208, 32'h180, 32'h400,
      mk(0, 1, 32'h100, 32'h180), mk(1, 0, 32'h208, 32'h400), '0, '0, 2, 0));
    vecs.push_back(mkvec("same_index", 2'b11, 2'b11, 2'b00, 2'b00,
      32'h100, 32'h500, 32'h104, 32'h504,
      mk(0, 0, 32'h100, 32'h104), '0, mk(0, 0, 32'h500, 32'h504), '0, 2, 1));
    vecs.push_back(mkvec("compaction", 2'b11, 2'b10, 2'b00, 2'b01,
      32'h40, 32'h3C, 32'h44, 32'h80,
      mk(0, 0, 32'h3C, 32'h80), '0, '0, '0, 1, 0));
    vecs.push_back(mkvec("no_valid", 2'b00, 2'b11, 2'b11, 2'b11,
      32'h100, 32'h208, 32'h1, 32'h2, '0, '0, '0, '0, 0, 0));
    vecs.push_back(mkvec("slot1_only", 2'b10, 2'b11, 2'b10, 2'b10,
      32'h900, 32'h7FC, 32'h0, 32'h1000,
      mk(1, 1, 32'h7FC, 32'h1000), '0, '0, '0, 1, 0));
    vecs.push_back(mkvec("idx_top_bit", 2'b11, 2'b11, 2'b00, 2'b00,
      32'h7FC, 32'h3FC, 32'hA0, 32'hB0,
      mk(0, 0, 32'h7FC, 32'hA0), '0, mk(0, 0, 32'h3FC, 32'hB0), '0, 2, 1));
    vecs.push_back(mkvec("below_idx_lo", 2'b11, 2'b11, 2'b01, 2'b00,
      32'h100, 32'h102, 32'hC0, 32'hD0,
      mk(1, 0, 32'h100, 32'hC0), '0, mk(0, 0, 32'h102, 32'hD0), '0, 2, 1));
    vecs.push_back(mkvec("at_idx_lo", 2'b11, 2'b11, 2'b00, 2'b11,
      32'h100, 32'h104, 32'hE0, 32'hF0,
      mk(0, 1, 32'h100, 32'hE0), mk(0, 1, 32'h104, 32'hF0), '0, '0, 2, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      do_reset();
      @(posedge clock); #1;
      drive(vecs[i].v, vecs[i].br, vecs[i].u, vecs[i].m,
            vecs[i].p0, vecs[i].p1, vecs[i].t0, vecs[i].t1);
      #1;
      chk_pkt({vecs[i].name, ".t0.slot0"}, rob_packet[0], '0);
      @(posedge clock); #1;
      idle();
      #1;
      chk_pkt({vecs[i].name, ".t1.slot0"}, rob_packet[0], vecs[i].e1_0);
      chk_pkt({vecs[i].name, ".t1.slot1"}, rob_packet[1], vecs[i].e1_1);
      chk_int({vecs[i].name, ".t1.q_count"}, int'(q_count), vecs[i].q1);
      @(posedge clock); #2;
      chk_pkt({vecs[i].name, ".t2.slot0"}, rob_packet[0], vecs[i].e2_0);
      chk_pkt({vecs[i].name, ".t2.slot1"}, rob_packet[1], vecs[i].e2_1);
      chk_int({vecs[i].name, ".t2.q_count"}, int'(q_count), vecs[i].q2);
    end
  endtask

  task automatic test_fill_overflow();
    logic [31:0] acc[$];
    int          exp_q;
    do_reset();
    exp_q = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); #1;
      drive(2'b11, 2'b11, 2'b00, 2'b00, spc(2*c), spc(2*c+1), 32'h8000 + 32'(2*c), 32'h8000 + 32'(2*c+1));
      #1;
      chk_int($sformatf("fill%0d.q_count", c), int'(q_count), exp_q);
      chk_int($sformatf("fill%0d.ready", c), int'(retire_ready), 1);
      if (c >= 1) begin
        chk_int($sformatf("fill%0d.slot0_pc", c), int'(rob_packet[0].pc), int'(acc[c-1]));
        chk_pkt($sformatf("fill%0d.slot1", c), rob_packet[1], '0);
      end
      acc.push_back(spc(2*c));
      acc.push_back(spc(2*c+1));
      exp_q = (c == 0) ? 2 : exp_q + 1;
    end
    @(posedge clock); #1;
    drive(2'b11, 2'b11, 2'b00, 2'b00, spc(12), spc(13), 32'h9000, 32'h9001);
    #1;
    chk_int("full.q_count", int'(q_count), 7);
    chk_int("full.ready", int'(retire_ready), 0);
    chk_int("full.slot0_pc", int'(rob_packet[0].pc), int'(acc[5]));
    @(posedge clock); #1;
    idle();
    #1;
    chk_int("overflow.q_count", int'(q_count), 6);
    chk_int("overflow.drop_cnt", int'(drop_cnt), 2);
    for (int i = 6; i < 12; i++) begin
      chk_int($sformatf("drain%0d.slot0_pc", i), int'(rob_packet[0].pc), int'(acc[i]));
      chk_int($sformatf("drain%0d.slot0_br", i), int'(rob_packet[0].isbranch), 1);
      chk_pkt($sformatf("drain%0d.slot1", i), rob_packet[1], '0);
      @(posedge clock); #2;
    end
    chk_int("drained.q_count", int'(q_count), 0);
    chk_pkt("drained.slot0", rob_packet[0], '0);

    for (int c = 0; c < 2; c++) begin
      @(posedge clock); #1;
      drive(2'b11, 2'b11, 2'b00, 2'b00, spc(20+c), spc(30+c), 32'h1, 32'h2);
    end
    @(posedge clock); #1;
    idle();
    #1;
    chk_int("pre_reset.q_count", int'(q_count), 3);
    chk_int("pre_reset.drop_cnt", int'(drop_cnt), 2);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk_int("mid_reset.q_count", int'(q_count), 0);
    chk_int("mid_reset.drop_cnt", int'(drop_cnt), 0);
    chk_int("mid_reset.ready", int'(retire_ready), 1);
    chk_pkt("mid_reset.slot0", rob_packet[0], '0);
    chk_pkt("mid_reset.slot1", rob_packet[1], '0);
  endtask

  task automatic test_bypass();
    do_reset();
    @(posedge clock); #1;
    drive(2'b11, 2'b11, 2'b00, 2'b00, 32'h100, 32'h208, 32'h180, 32'h400);
    #1;
    chk_pkt("bypass.t0.slot0", rob_packet[0], mk(0, 0, 32'h100, 32'h180));
    chk_pkt("bypass.t0.slot1", rob_packet[1], mk(0, 0, 32'h208, 32'h400));
    chk_int("bypass.t0.q_count", int'(q_count), 0);
    @(posedge clock); #1;
    idle();
    #1;
    chk_int("bypass.t1.q_count", int'(q_count), 0);
    chk_pkt("bypass.t1.slot0", rob_packet[0], '0);
  endtask

  task automatic run_random(input int ncyc);
    ROB_BTB_packet mq[$];
    int            mdrop;
    do_reset();
    mdrop = 0;
    for (int c = 0; c < ncyc; c++) begin
      ROB_BTB_packet cands[$];
      ROB_BTB_packet srcq[$];
      ROB_BTB_packet expp[W];
      logic [1:0]    v, br, u, m;
      logic [31:0]   pc[W];
      logic [31:0]   tg[W];
      int            thr, n;
      bit            byp, ready_exp, dup;
      cands.delete();
      srcq.delete();
      thr = (((c / 150) % 2) == 0) ? 90 : 30;
      for (int k = 0; k < W; k++) begin
        v[k]  = ($urandom_range(0, 99) < thr);
        br[k] = ($urandom_range(0, 3) != 0);
        u[k]  = 1'($urandom_range(0, 1));
        m[k]  = 1'($urandom_range(0, 1));
        pc[k] = (32'($urandom_range(0, 15)) << 10) | (32'($urandom_range(0, 3)) << 2)
              | 32'($urandom_range(0, 3));
        tg[k] = $urandom;
      end
      @(posedge clock); #1;
      drive(v, br, u, m, pc[0], pc[1], tg[0], tg[1]);
      #1;
      for (int k = 0; k < W; k++)
        if (v[k] && br[k]) cands.push_back(mk(u[k], m[k], pc[k], tg[k]));
      byp = 1'b0;
`ifdef BTB_UPD_BYPASS_EN
      byp = (mq.size() == 0);
`endif
      srcq = byp ? cands : mq;
      ready_exp = (DEPTH - mq.size()) >= W;
      for (int j = 0; j < W; j++) expp[j] = '0;
      n = 0;
      for (int j = 0; j < W && j < srcq.size(); j++) begin
        dup = 1'b0;
        for (int p = 0; p < n; p++)
          if (expp[p].pc[9:2] == srcq[j].pc[9:2]) dup = 1'b1;
        if (dup) break;
        expp[j] = srcq[j];
        n++;
      end
      chk_pkt($sformatf("rand%0d.slot0", c), rob_packet[0], expp[0]);
      chk_pkt($sformatf("rand%0d.slot1", c), rob_packet[1], expp[1]);
      chk_int($sformatf("rand%0d.q_count", c), int'(q_count), mq.size());
      chk_int($sformatf("rand%0d.ready", c), int'(retire_ready), int'(ready_exp));
      chk_int($sformatf("rand%0d.drop_cnt", c), int'(drop_cnt), mdrop);
      if (byp) begin
        for (int j = n; j < cands.size(); j++) mq.push_back(cands[j]);
      end else begin
        for (int j = 0; j < n; j++) void'(mq.pop_front());
        if (cands.size() > 0) begin
          if (ready_exp) begin
            for (int j = 0; j < cands.size(); j++) mq.push_back(cands[j]);
          end else begin
            mdrop = mdrop + cands.size();
            if (mdrop > 255) mdrop = 255;
          end
        end
      end
    end
    @(posedge clock); #1;
    idle();
  endtask

  initial begin
    idle();
    test_reset();
`ifdef BTB_UPD_BYPASS_EN
    test_bypass();
`else
    test_vectors();
    test_fill_overflow();
`endif
    run_random(3000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
